// File: rtl/touch_key_decoder.sv
// Touch-panel key decoder: maps registered touch coordinates onto a button grid,
// debounces the press and emits one key_valid pulse per confirmed press/release cycle.
module touch_key_decoder #(
   parameter int unsigned DEBOUNCE_CYC = 500000,
   parameter int unsigned RELEASE_CYC  = 500000,
   parameter int unsigned X0           = 40,
   parameter int unsigned Y0           = 120,
   parameter int unsigned CELL_W       = 180,
   parameter int unsigned CELL_H       = 120,
   parameter int unsigned KEY_COLS     = 4,
   parameter int unsigned KEY_ROWS     = 3
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [31:0] touch_data,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic        key_hold,
   output logic [15:0] key_x,
   output logic [15:0] key_y
);

   localparam int unsigned MAX_CYC = (DEBOUNCE_CYC > RELEASE_CYC) ? DEBOUNCE_CYC : RELEASE_CYC;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

   typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED} state_t;

   state_t           r_state;
   logic [31:0]      r_touch;
   logic [3:0]       r_cand;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_rcnt;

   logic [16:0] w_x;
   logic [16:0] w_y;
   logic [1:0]  w_col;
   logic [1:0]  w_row;
   logic [3:0]  w_code;
   logic        w_touch;
   logic        w_in_grid;
   logic        w_cell;
   logic        w_restart;
   logic        w_accept;

   // 17-bit coordinates keep the grid's far edge from wrapping
   assign w_x     = {1'b0, r_touch[31:16]};
   assign w_y     = {1'b0, r_touch[15:0]};
   assign w_touch = (r_touch != 32'h0);

   // Cell index by threshold counting; no divider needed
   always_comb begin
      w_col = '0;
      w_row = '0;
      for (int unsigned k = 1; k < KEY_COLS; k++) begin
         if (w_x >= 17'(X0 + k * CELL_W)) w_col = w_col + 2'd1;
      end
      for (int unsigned k = 1; k < KEY_ROWS; k++) begin
         if (w_y >= 17'(Y0 + k * CELL_H)) w_row = w_row + 2'd1;
      end
   end

   assign w_in_grid = (w_x >= 17'(X0)) && (w_x < 17'(X0 + KEY_COLS * CELL_W)) &&
                      (w_y >= 17'(Y0)) && (w_y < 17'(Y0 + KEY_ROWS * CELL_H));
   assign w_code    = ({2'b00, w_row} * 4'(KEY_COLS)) + {2'b00, w_col};
   assign w_cell    = w_touch && w_in_grid;

   // A new candidate starts the count at 1, so a single-cycle debounce accepts immediately
   assign w_restart = w_cell && ((r_state == S_IDLE) ||
                                 ((r_state == S_DEBOUNCE) && (w_code != r_cand)));
   assign w_accept  = w_cell && ((w_restart && (DEBOUNCE_CYC == 1)) ||
                                 ((r_state == S_DEBOUNCE) && (w_code == r_cand) &&
                                  (r_cnt >= CNT_W'(DEBOUNCE_CYC - 1))));

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state   <= S_IDLE;
         r_touch   <= '0;
         r_cand    <= '0;
         r_cnt     <= '0;
         r_rcnt    <= '0;
         key_valid <= 1'b0;
         key_code  <= '0;
         key_hold  <= 1'b0;
         key_x     <= '0;
         key_y     <= '0;
      end else begin
         r_touch   <= touch_data;
         key_valid <= 1'b0;
         if (w_accept) begin
            r_state   <= S_PRESSED;
            r_cand    <= w_code;
            r_cnt     <= CNT_W'(DEBOUNCE_CYC);
            r_rcnt    <= '0;
            key_valid <= 1'b1;
            key_code  <= w_code;
            key_hold  <= 1'b1;
            key_x     <= r_touch[31:16];
            key_y     <= r_touch[15:0];
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_restart) begin
                     r_state <= S_DEBOUNCE;
                     r_cand  <= w_code;
                     r_cnt   <= CNT_W'(1);
                  end
               end
               S_DEBOUNCE: begin
                  if (!w_cell) begin
                     r_state <= S_IDLE;
                     r_cnt   <= '0;
                  end else if (w_restart) begin
                     r_cand <= w_code;
                     r_cnt  <= CNT_W'(1);
                  end else if (r_cnt < CNT_W'(DEBOUNCE_CYC)) begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               S_PRESSED: begin
                  key_hold <= 1'b1;
                  // Any nonzero word, even off-grid, counts as still pressed
                  if (w_touch) begin
                     r_rcnt <= '0;
                  end else if (r_rcnt >= CNT_W'(RELEASE_CYC - 1)) begin
                     r_state  <= S_IDLE;
                     r_rcnt   <= '0;
                     r_cnt    <= '0;
                     key_hold <= 1'b0;
                  end else begin
                     r_rcnt <= r_rcnt + CNT_W'(1);
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_touch_key_decoder.sv
// Directed bench for touch_key_decoder: segment table of held touch words with
// hand-computed pulse position, held outputs and key_hold low-cycle counts.
module tb_touch_key_decoder;

   localparam logic [31:0] P0   = {16'd100, 16'd150};
   localparam logic [31:0] P1   = {16'd300, 16'd150};
   localparam logic [31:0] P5   = {16'd300, 16'd300};
   localparam logic [31:0] P10  = {16'd400, 16'd400};
   localparam logic [31:0] OFF  = {16'd10,  16'd10};
   localparam logic [31:0] YZ   = {16'd5,   16'd0};
   localparam logic [31:0] REDG = {16'd760, 16'd479};
   localparam logic [31:0] TL   = {16'd40,  16'd120};
   localparam logic [31:0] BR   = {16'd759, 16'd479};

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic [31:0] touch_data = 32'h0;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_hold;
   logic [15:0] key_x;
   logic [15:0] key_y;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] data;
      int          ncyc;
      int          pulse_at;
      logic [3:0]  code;
      logic [15:0] kx;
      logic [15:0] ky;
      int          hold_lo;
   } seg_t;

   seg_t segs[$];

   touch_key_decoder #(
      .DEBOUNCE_CYC(4),
      .RELEASE_CYC (3)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .touch_data(touch_data),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_hold  (key_hold),
      .key_x     (key_x),
      .key_y     (key_y)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Input changes 1 time unit after the edge; outputs sampled at the falling edge
   task automatic run_seg(input seg_t s, input int id);
      int npulse = 0;
      int first  = -1;
      int lo     = 0;
      for (int i = 0; i < s.ncyc; i++) begin
         @(posedge sys_clk);
         #1 touch_data = s.data;
         @(negedge sys_clk);
         if (key_valid === 1'b1) begin
            npulse++;
            if (first < 0) first = i;
         end
         if (key_hold !== 1'b1) lo++;
      end
      chk($sformatf("seg%0d_pulses", id), 32'(npulse), (s.pulse_at >= 0) ? 32'd1 : 32'd0);
      if (s.pulse_at >= 0) chk($sformatf("seg%0d_pulse_cycle", id), 32'(first), 32'(s.pulse_at));
      chk($sformatf("seg%0d_code", id), 32'(key_code), 32'(s.code));
      chk($sformatf("seg%0d_x", id), 32'(key_x), 32'(s.kx));
      chk($sformatf("seg%0d_y", id), 32'(key_y), 32'(s.ky));
      chk($sformatf("seg%0d_hold_low_cycles", id), 32'(lo), 32'(s.hold_lo));
   endtask

   initial begin
      int npulse;

      segs.push_back('{P0,   10,  5, 4'd0,  16'd100, 16'd150,  5});
      segs.push_back('{32'h0, 5, -1, 4'd0,  16'd100, 16'd150,  1});
      segs.push_back('{P10,   8,  5, 4'd10, 16'd400, 16'd400,  5});
      segs.push_back('{32'h0, 5, -1, 4'd10, 16'd400, 16'd400,  1});
      segs.push_back('{P0,    2, -1, 4'd10, 16'd400, 16'd400,  2});
      segs.push_back('{P1,    4, -1, 4'd10, 16'd400, 16'd400,  4});
      segs.push_back('{32'h0, 6,  1, 4'd1,  16'd300, 16'd150,  3});
      segs.push_back('{OFF,  20, -1, 4'd1,  16'd300, 16'd150, 20});
      segs.push_back('{P10,   6,  5, 4'd10, 16'd400, 16'd400,  5});
      segs.push_back('{32'h0, 2, -1, 4'd10, 16'd400, 16'd400,  0});
      segs.push_back('{YZ,    1, -1, 4'd10, 16'd400, 16'd400,  0});
      segs.push_back('{32'h0, 6, -1, 4'd10, 16'd400, 16'd400,  2});
      segs.push_back('{REDG,  8, -1, 4'd10, 16'd400, 16'd400,  8});
      segs.push_back('{TL,    7,  5, 4'd0,  16'd40,  16'd120,  5});
      segs.push_back('{32'h0, 5, -1, 4'd0,  16'd40,  16'd120,  1});
      segs.push_back('{BR,    7,  5, 4'd11, 16'd759, 16'd479,  5});
      segs.push_back('{32'h0, 5, -1, 4'd11, 16'd759, 16'd479,  1});

      // Reset state
      repeat (3) @(negedge sys_clk);
      chk("reset_valid", 32'(key_valid), 32'd0);
      chk("reset_code",  32'(key_code),  32'd0);
      chk("reset_hold",  32'(key_hold),  32'd0);
      chk("reset_x",     32'(key_x),     32'd0);
      chk("reset_y",     32'(key_y),     32'd0);
      sys_rst = 1'b0;

      foreach (segs[i]) run_seg(segs[i], i);

      // Reset in the middle of a debounce with cnt = 3
      npulse = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge sys_clk);
         #1 touch_data = P5;
         @(negedge sys_clk);
         if (key_valid === 1'b1) npulse++;
      end
      chk("pre_rst_pulses", 32'(npulse), 32'd0);
      chk("pre_rst_code",   32'(key_code), 32'd11);
      #2 sys_rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(key_valid), 32'd0);
      chk("mid_rst_code",  32'(key_code),  32'd0);
      chk("mid_rst_hold",  32'(key_hold),  32'd0);
      chk("mid_rst_x",     32'(key_x),     32'd0);
      chk("mid_rst_y",     32'(key_y),     32'd0);
      touch_data = 32'h0;
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
      run_seg('{32'h0, 2, -1, 4'd0, 16'd0,   16'd0,   2}, 100);
      run_seg('{P5,    8,  5, 4'd5, 16'd300, 16'd300, 5}, 101);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
